// File: rtl/level_sample_sequencer.sv
// Level-sample sequencer: accepts a 10-bit level, range-checks it, converts it to
// BCD with a shift-add-3 engine and commits digits plus hysteresis alarms atomically.
module level_sample_sequencer #(
  parameter int HI_LIMIT  = 900,
  parameter int LO_LIMIT  = 100,
  parameter int HYST      = 5,
  parameter int MAX_LEVEL = 999
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic [9:0] sample_data,
  output logic       sample_ready,
  output logic [3:0] data_h,
  output logic [3:0] data_t,
  output logic [3:0] data_u,
  output logic       GOET,
  output logic       LOET,
  output logic       input_error,
  output logic       update_done
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CHECK   = 2'd1;
  localparam logic [1:0] CONVERT = 2'd2;
  localparam logic [1:0] COMMIT  = 2'd3;

  localparam logic [9:0] MAX_LVL = 10'(MAX_LEVEL);
  localparam logic [9:0] HI_SET  = 10'(HI_LIMIT);
  localparam logic [9:0] HI_CLR  = 10'(HI_LIMIT - HYST);
  localparam logic [9:0] LO_SET  = 10'(LO_LIMIT);
  localparam logic [9:0] LO_CLR  = 10'(LO_LIMIT + HYST);

  logic [1:0]  state_q, state_d;
  logic [9:0]  sample_q, sample_d;
  logic [9:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0]  iter_q, iter_d;
  logic [3:0]  data_h_q, data_h_d, data_t_q, data_t_d, data_u_q, data_u_d;
  logic        goet_q, goet_d, loet_q, loet_d;
  logic        err_q, err_d, done_q, done_d;

  logic [11:0] bcd_adj;
  logic [21:0] shifted;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3
                                                      : bcd_q[i*4 +: 4];
    end
    shifted = {bcd_adj[10:0], bin_q, 1'b0};
  end

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    sample_d = sample_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    iter_d   = iter_q;
    data_h_d = data_h_q;
    data_t_d = data_t_q;
    data_u_d = data_u_q;
    goet_d   = goet_q;
    loet_d   = loet_q;
    err_d    = err_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          sample_d = sample_data;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (sample_q > MAX_LVL) begin
          err_d   = 1'b1;
          goet_d  = 1'b0;
          loet_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          bcd_d   = '0;
          bin_d   = sample_q;
          iter_d  = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d  = shifted[21:10];
        bin_d  = shifted[9:0];
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd9) state_d = COMMIT;
      end
      COMMIT: begin
        data_h_d = bcd_q[11:8];
        data_t_d = bcd_q[7:4];
        data_u_d = bcd_q[3:0];
        err_d    = 1'b0;
        // Between the set and clear points each alarm keeps its previous value.
        if (sample_q >= HI_SET)      goet_d = 1'b1;
        else if (sample_q < HI_CLR)  goet_d = 1'b0;
        if (sample_q <= LO_SET)      loet_d = 1'b1;
        else if (sample_q > LO_CLR)  loet_d = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sample_q <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      data_h_q <= '0;
      data_t_q <= '0;
      data_u_q <= '0;
      goet_q   <= 1'b0;
      loet_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      iter_q   <= iter_d;
      data_h_q <= data_h_d;
      data_t_q <= data_t_d;
      data_u_q <= data_u_d;
      goet_q   <= goet_d;
      loet_q   <= loet_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign sample_ready = (state_q == IDLE);
  assign data_h       = data_h_q;
  assign data_t       = data_t_q;
  assign data_u       = data_u_q;
  assign GOET         = goet_q;
  assign LOET         = loet_q;
  assign input_error  = err_q;
  assign update_done  = done_q;

endmodule

// File: tb/tb_level_sample_sequencer.sv
// Scoreboard bench for level_sample_sequencer: stimulus pushes expected commits,
// a negedge monitor pops and compares on every update_done pulse.
module tb_level_sample_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_valid;
  logic [9:0] sample_data;
  logic       sample_ready;
  logic [3:0] data_h, data_t, data_u;
  logic       GOET, LOET, input_error, update_done;

  level_sample_sequencer dut (
    .clk_100MHz  (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .sample_ready(sample_ready),
    .data_h      (data_h),
    .data_t      (data_t),
    .data_u      (data_u),
    .GOET        (GOET),
    .LOET        (LOET),
    .input_error (input_error),
    .update_done (update_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int h, t, u;
    int goet, loet, err;
    int lat;
    int acc;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // Reference model state: last committed digits and alarm flags.
  int m_h = 0, m_t = 0, m_u = 0, m_goet = 0, m_loet = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_push(input int v, input int acc);
    exp_t e;
    if (v > 999) begin
      m_goet = 0;
      m_loet = 0;
      e = '{h: m_h, t: m_t, u: m_u, goet: 0, loet: 0, err: 1, lat: 1, acc: acc};
    end else begin
      m_h = v / 100;
      m_t = (v / 10) % 10;
      m_u = v % 10;
      if (v >= 900)      m_goet = 1;
      else if (v < 895)  m_goet = 0;
      if (v <= 100)      m_loet = 1;
      else if (v > 105)  m_loet = 0;
      e = '{h: m_h, t: m_t, u: m_u, goet: m_goet, loet: m_loet, err: 0, lat: 12, acc: acc};
    end
    exp_q.push_back(e);
  endtask

  task automatic send(input int v, input bit keep_valid, output int acc);
    int n = 0;
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = 10'(v);
    while (sample_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sample_ready !== 1'b1) check("accept_timeout", sample_ready, 1);
    @(posedge clk);
    #1;
    acc = cyc;
    model_push(v, acc);
    if (!keep_valid) sample_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: compares every committed update against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (update_done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", update_done, 0);
        end else begin
          e = exp_q.pop_front();
          check("data_h",      data_h,      e.h);
          check("data_t",      data_t,      e.t);
          check("data_u",      data_u,      e.u);
          check("GOET",        GOET,        e.goet);
          check("LOET",        LOET,        e.loet);
          check("input_error", input_error, e.err);
          check("latency",     cyc - e.acc, e.lat);
          check("ready_at_done", sample_ready, 1);
        end
      end
    end
  end

  initial begin
    int a0, a1, a2, a3, dc;
    reset = 1'b1;
    sample_valid = 1'b0;
    sample_data = '0;
    repeat (3) @(negedge clk);
    check("rst_data_h", data_h, 0);
    check("rst_data_t", data_t, 0);
    check("rst_data_u", data_u, 0);
    check("rst_goet",   GOET, 0);
    check("rst_loet",   LOET, 0);
    check("rst_err",    input_error, 0);
    check("rst_done",   update_done, 0);
    check("rst_ready",  sample_ready, 1);
    reset = 1'b0;

    // Mid-range sample with ready profile across the conversion.
    send(487, 1'b0, a0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("ready_busy_487", sample_ready, 0);
    end
    @(negedge clk);
    check("ready_back_487", sample_ready, 1);
    check("done_487", update_done, 1);
    drain();

    // High alarm with hysteresis.
    send(999, 1'b0, a0);
    send(896, 1'b0, a0);
    send(894, 1'b0, a0);
    send(899, 1'b0, a0);
    drain();

    // Out of range, then recovery through the low alarm band.
    send(1000, 1'b0, a0);
    send(50,   1'b0, a0);
    send(105,  1'b0, a0);
    send(106,  1'b0, a0);
    drain();

    // Reset in the middle of CONVERT.
    send(600, 1'b0, a0);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_data_h", data_h, 0);
    check("mid_rst_data_t", data_t, 0);
    check("mid_rst_data_u", data_u, 0);
    check("mid_rst_goet",   GOET, 0);
    check("mid_rst_loet",   LOET, 0);
    check("mid_rst_err",    input_error, 0);
    check("mid_rst_ready",  sample_ready, 1);
    exp_q.delete();
    m_h = 0; m_t = 0; m_u = 0; m_goet = 0; m_loet = 0;
    dc = done_cnt;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("no_done_after_rst", done_cnt - dc, 0);

    // Back-to-back stream with valid held high.
    dc = done_cnt;
    send(0,   1'b1, a0);
    send(1,   1'b1, a1);
    send(10,  1'b1, a2);
    send(100, 1'b0, a3);
    check("stream_gap1", a1 - a0, 13);
    check("stream_gap2", a2 - a1, 13);
    check("stream_gap3", a3 - a2, 13);
    drain();
    repeat (5) @(negedge clk);
    check("stream_done_count", done_cnt - dc, 4);

    // Exhaustive conversion sweep.
    for (int v = 0; v < 1000; v++) send(v, (v != 999), a0);
    drain();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
